// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the 2-D pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } pool_state_e;

    // Number of whole windows along one axis; trailing pixels are dropped.
    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pool_reduce.sv
// Combinational fold of one sample into the window accumulator, plus the final
// scaling that turns the accumulator into a pooled pixel.
module pool_reduce
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 2,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH+$clog2(K*K)-1:0] acc,
    input  logic [DATA_WIDTH-1:0]             sample,
    input  pool_mode_e                        mode,
    input  logic                              first,
    output logic [DATA_WIDTH+$clog2(K*K)-1:0] acc_next,
    output logic [DATA_WIDTH-1:0]             result
);

    localparam int  KK     = K * K;
    localparam int  SHIFT  = $clog2(KK);
    localparam int  ACC_W  = DATA_WIDTH + SHIFT;
    localparam bit  AVG_OK = is_pow2(KK);

    logic [ACC_W-1:0] sample_ext;
    logic             sample_gt;
    logic             use_avg;

    assign sample_ext = (SIGNED != 0) ? ACC_W'($signed(sample)) : ACC_W'(sample);
    assign sample_gt  = (SIGNED != 0) ? ($signed(sample_ext) > $signed(acc))
                                      : (sample_ext > acc);
    // Averaging needs a pure shift; other window sizes fall back to MAX.
    assign use_avg    = (mode == POOL_AVG) && AVG_OK;

    always_comb begin
        acc_next = acc;
        if (first) begin
            acc_next = sample_ext;
        end else if (use_avg) begin
            acc_next = acc + sample_ext;
        end else if (sample_gt) begin
            acc_next = sample_ext;
        end
    end

    assign result = use_avg
                  ? ((SIGNED != 0) ? DATA_WIDTH'($signed(acc_next) >>> SHIFT)
                                   : DATA_WIDTH'(acc_next >> SHIFT))
                  : DATA_WIDTH'(acc_next);

endmodule

// File: rtl/pool2d_engine.sv
// Frame-level pooling sequencer: walks every KxK window of a BRAM-resident image,
// reduces it through pool_reduce and writes one result per window.
module pool2d_engine
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 4,
    parameter int KERNEL_DIM = 2,
    parameter int STRIDE     = 2,
    parameter int RD_LATENCY = 1,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] rd_base,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int OUT_W = out_dim(IMG_W, KERNEL_DIM, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, KERNEL_DIM, STRIDE);
    localparam int ACC_W = DATA_WIDTH + $clog2(KERNEL_DIM * KERNEL_DIM);
    localparam int DCW   = $clog2(RD_LATENCY + 1);

    localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(KERNEL_DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] OX_LAST  = ADDR_WIDTH'(OUT_W - 1);
    localparam logic [ADDR_WIDTH-1:0] OY_LAST  = ADDR_WIDTH'(OUT_H - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] OUT_W_A  = ADDR_WIDTH'(OUT_W);
    localparam logic [DCW-1:0]        D_LAST   = DCW'(RD_LATENCY - 1);

    pool_state_e             state_reg;
    pool_mode_e              mode_reg;
    logic [ADDR_WIDTH-1:0]   rd_base_reg, wr_base_reg;
    logic [ADDR_WIDTH-1:0]   kx_reg, ky_reg, ox_reg, oy_reg;
    logic [DCW-1:0]          drain_reg;
    logic [RD_LATENCY-1:0]   valid_sr_reg;
    logic [ACC_W-1:0]        acc_reg, acc_next;
    logic                    first_reg;
    logic [DATA_WIDTH-1:0]   result;
    logic                    sample_valid;
    logic                    busy_reg, done_reg, rd_en_reg, wr_en_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg, wr_addr_reg;
    logic [DATA_WIDTH-1:0]   wr_data_reg;

    // All address arithmetic wraps naturally at ADDR_WIDTH bits.
    function automatic logic [ADDR_WIDTH-1:0] rd_offset(
        input logic [ADDR_WIDTH-1:0] ox, input logic [ADDR_WIDTH-1:0] oy,
        input logic [ADDR_WIDTH-1:0] kx, input logic [ADDR_WIDTH-1:0] ky);
        return (oy * STRIDE_A + ky) * IMG_W_A + ox * STRIDE_A + kx;
    endfunction

    assign sample_valid = valid_sr_reg[RD_LATENCY-1];

    pool_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (KERNEL_DIM),
        .SIGNED     (SIGNED)
    ) u_reduce (
        .acc      (acc_reg),
        .sample   (rd_data),
        .mode     (mode_reg),
        .first    (first_reg),
        .acc_next (acc_next),
        .result   (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            mode_reg     <= POOL_MAX;
            rd_base_reg  <= '0;
            wr_base_reg  <= '0;
            kx_reg       <= '0;
            ky_reg       <= '0;
            ox_reg       <= '0;
            oy_reg       <= '0;
            drain_reg    <= '0;
            valid_sr_reg <= '0;
            acc_reg      <= '0;
            first_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_en_reg    <= 1'b0;
            rd_addr_reg  <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            valid_sr_reg <= (valid_sr_reg << 1) | RD_LATENCY'(rd_en_reg);
            if (sample_valid) begin
                acc_reg   <= acc_next;
                first_reg <= 1'b0;
            end

            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg   <= READ;
                        busy_reg    <= 1'b1;
                        mode_reg    <= pool_mode_e'(mode);
                        rd_base_reg <= rd_base;
                        wr_base_reg <= wr_base;
                        kx_reg      <= '0;
                        ky_reg      <= '0;
                        ox_reg      <= '0;
                        oy_reg      <= '0;
                        first_reg   <= 1'b1;
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= rd_base;
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                READ: begin
                    if (kx_reg == K_LAST && ky_reg == K_LAST) begin
                        state_reg <= DRAIN;
                        rd_en_reg <= 1'b0;
                        drain_reg <= '0;
                    end else if (kx_reg == K_LAST) begin
                        kx_reg      <= '0;
                        ky_reg      <= ky_reg + 1'b1;
                        rd_addr_reg <= rd_base_reg + rd_offset(ox_reg, oy_reg, '0, ky_reg + 1'b1);
                    end else begin
                        kx_reg      <= kx_reg + 1'b1;
                        rd_addr_reg <= rd_base_reg + rd_offset(ox_reg, oy_reg, kx_reg + 1'b1, ky_reg);
                    end
                end

                DRAIN: begin
                    // The window's last sample lands in the final DRAIN cycle.
                    if (drain_reg == D_LAST) begin
                        state_reg   <= WRITE;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= wr_base_reg + oy_reg * OUT_W_A + ox_reg;
                        wr_data_reg <= result;
                    end else begin
                        drain_reg <= drain_reg + 1'b1;
                    end
                end

                WRITE: begin
                    wr_en_reg <= 1'b0;
                    if (ox_reg == OX_LAST && oy_reg == OY_LAST) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= READ;
                        kx_reg    <= '0;
                        ky_reg    <= '0;
                        first_reg <= 1'b1;
                        rd_en_reg <= 1'b1;
                        if (ox_reg == OX_LAST) begin
                            ox_reg      <= '0;
                            oy_reg      <= oy_reg + 1'b1;
                            rd_addr_reg <= rd_base_reg + rd_offset('0, oy_reg + 1'b1, '0, '0);
                        end else begin
                            ox_reg      <= ox_reg + 1'b1;
                            rd_addr_reg <= rd_base_reg + rd_offset(ox_reg + 1'b1, oy_reg, '0, '0);
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule
